// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: pipeline-side hazard/memory status in, stall/flush/forward controls out.
// The controller attaches through the slave modport; the pipeline (or a bench) through master.
interface pipe_hazard_if #(
    parameter int STAT_W = 16
);
    logic [4:0]        id_rj_i;
    logic [4:0]        id_rk_i;
    logic              id_use_rj_i;
    logic              id_use_rk_i;
    logic [4:0]        ex_rd_i;
    logic              ex_regwrite_i;
    logic              ex_is_load_i;
    logic [4:0]        mem_rd_i;
    logic              mem_regwrite_i;
    logic              br_taken_i;
    logic              dm_req_i;
    logic              dm_ack_i;

    logic              stall_if_o;
    logic              stall_id_o;
    logic              stall_ex_o;
    logic              stall_mem_o;
    logic              flush_id_o;
    logic              flush_ex_o;
    logic              flush_wb_o;
    logic [1:0]        fwd_rj_sel_o;
    logic [1:0]        fwd_rk_sel_o;
    logic              mem_err_o;
    logic [STAT_W-1:0] stall_cnt_o;

    modport master (
        output id_rj_i, id_rk_i, id_use_rj_i, id_use_rk_i,
               ex_rd_i, ex_regwrite_i, ex_is_load_i,
               mem_rd_i, mem_regwrite_i, br_taken_i, dm_req_i, dm_ack_i,
        input  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
               flush_id_o, flush_ex_o, flush_wb_o,
               fwd_rj_sel_o, fwd_rk_sel_o, mem_err_o, stall_cnt_o
    );

    modport slave (
        input  id_rj_i, id_rk_i, id_use_rj_i, id_use_rk_i,
               ex_rd_i, ex_regwrite_i, ex_is_load_i,
               mem_rd_i, mem_regwrite_i, br_taken_i, dm_req_i, dm_ack_i,
        output stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
               flush_id_o, flush_ex_o, flush_wb_o,
               fwd_rj_sel_o, fwd_rk_sel_o, mem_err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW, taken-branch and data-memory wait handling.
// Define PIPE_FWD_EN to enable EX/MEM operand forwarding (RAW then stalls only on load-use).
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int STAT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  hz
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wcnt_q, wcnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic              rj_ex_m, rj_mem_m, rk_ex_m, rk_mem_m;
    logic              raw;
    logic [1:0]        fwd_rj, fwd_rk;

    logic              stall_if, stall_id, stall_ex, stall_mem;
    logic              flush_id, flush_ex, flush_wb;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // r0 is hardwired zero, so it never creates a dependency
    function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                       input logic regwrite, input logic [4:0] dst);
        return use_src && (src != 5'd0) && regwrite && (dst == src);
    endfunction

    assign rj_ex_m  = src_match(hz.id_use_rj_i, hz.id_rj_i, hz.ex_regwrite_i,  hz.ex_rd_i);
    assign rk_ex_m  = src_match(hz.id_use_rk_i, hz.id_rk_i, hz.ex_regwrite_i,  hz.ex_rd_i);
    assign rj_mem_m = src_match(hz.id_use_rj_i, hz.id_rj_i, hz.mem_regwrite_i, hz.mem_rd_i);
    assign rk_mem_m = src_match(hz.id_use_rk_i, hz.id_rk_i, hz.mem_regwrite_i, hz.mem_rd_i);

`ifdef PIPE_FWD_EN
    // A load result is not available until MEM completes, so only load-use must stall
    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m, input logic ex_ld);
        if (ex_m && !ex_ld) return 2'b01;
        if (mem_m)          return 2'b10;
        return 2'b00;
    endfunction

    assign raw    = hz.ex_is_load_i && (rj_ex_m || rk_ex_m);
    assign fwd_rj = fwd_sel(rj_ex_m, rj_mem_m, hz.ex_is_load_i);
    assign fwd_rk = fwd_sel(rk_ex_m, rk_mem_m, hz.ex_is_load_i);
`else
    logic unused_is_load;

    assign unused_is_load = hz.ex_is_load_i;
    assign raw    = rj_ex_m || rk_ex_m || rj_mem_m || rk_mem_m;
    assign fwd_rj = 2'b00;
    assign fwd_rk = 2'b00;
`endif

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_wb  = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (hz.dm_req_i && !hz.dm_ack_i) begin
                    {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                    flush_wb = 1'b1;
                    state_d  = S_MEM_WAIT;
                    wcnt_d   = TO_W'(1);
                end else if (hz.br_taken_i) begin
                    // The ID instruction is wrong-path, so its RAW stall is moot
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (raw) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end

            S_MEM_WAIT: begin
                if (hz.dm_ack_i) begin
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else begin
                    // EX is frozen here; branch and RAW are re-evaluated once released
                    {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                    flush_wb = 1'b1;
                    wcnt_d   = wcnt_q + 1'b1;
                    if (wcnt_q == TO_LIM) state_d = S_ERR;
                end
            end

            S_ERR: begin
                {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                flush_wb = 1'b1;
            end

            default: begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end
        endcase

        if (rst) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b0000;
            {flush_id, flush_ex, flush_wb}            = 3'b111;
        end
    end

    assign stall_cnt_d = stall_if ? sat_inc(stall_cnt_q) : stall_cnt_q;
    assign mem_err_d   = mem_err_q || (state_d == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign hz.stall_if_o   = stall_if;
    assign hz.stall_id_o   = stall_id;
    assign hz.stall_ex_o   = stall_ex;
    assign hz.stall_mem_o  = stall_mem;
    assign hz.flush_id_o   = flush_id;
    assign hz.flush_ex_o   = flush_ex;
    assign hz.flush_wb_o   = flush_wb;
    assign hz.fwd_rj_sel_o = rst ? 2'b00 : fwd_rj;
    assign hz.fwd_rk_sel_o = rst ? 2'b00 : fwd_rk;
    assign hz.mem_err_o    = mem_err_q;
    assign hz.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a RUN-state decode table plus memory-wait, timeout,
// stall-counter saturation and reset-during-wait sequences.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_if #(.STAT_W(16)) ifa ();
    pipe_hazard_if #(.STAT_W(16)) ifb ();
    pipe_hazard_if #(.STAT_W(3))  ifc ();

    pipe_hazard_ctrl #(.TIMEOUT(255), .TO_W(8), .STAT_W(16)) dut_a (.clk(clk), .rst(rst), .hz(ifa.slave));
    pipe_hazard_ctrl #(.TIMEOUT(3),   .TO_W(8), .STAT_W(16)) dut_b (.clk(clk), .rst(rst), .hz(ifb.slave));
    pipe_hazard_ctrl #(.TIMEOUT(255), .TO_W(8), .STAT_W(3))  dut_c (.clk(clk), .rst(rst), .hz(ifc.slave));

    // B and C see the same stimulus as A
    assign ifb.id_rj_i = ifa.id_rj_i;           assign ifc.id_rj_i = ifa.id_rj_i;
    assign ifb.id_rk_i = ifa.id_rk_i;           assign ifc.id_rk_i = ifa.id_rk_i;
    assign ifb.id_use_rj_i = ifa.id_use_rj_i;   assign ifc.id_use_rj_i = ifa.id_use_rj_i;
    assign ifb.id_use_rk_i = ifa.id_use_rk_i;   assign ifc.id_use_rk_i = ifa.id_use_rk_i;
    assign ifb.ex_rd_i = ifa.ex_rd_i;           assign ifc.ex_rd_i = ifa.ex_rd_i;
    assign ifb.ex_regwrite_i = ifa.ex_regwrite_i; assign ifc.ex_regwrite_i = ifa.ex_regwrite_i;
    assign ifb.ex_is_load_i = ifa.ex_is_load_i; assign ifc.ex_is_load_i = ifa.ex_is_load_i;
    assign ifb.mem_rd_i = ifa.mem_rd_i;         assign ifc.mem_rd_i = ifa.mem_rd_i;
    assign ifb.mem_regwrite_i = ifa.mem_regwrite_i; assign ifc.mem_regwrite_i = ifa.mem_regwrite_i;
    assign ifb.br_taken_i = ifa.br_taken_i;     assign ifc.br_taken_i = ifa.br_taken_i;
    assign ifb.dm_req_i = ifa.dm_req_i;         assign ifc.dm_req_i = ifa.dm_req_i;
    assign ifb.dm_ack_i = ifa.dm_ack_i;         assign ifc.dm_ack_i = ifa.dm_ack_i;

    // {stall_if,id,ex,mem, flush_id,ex,wb, fwd_rj[1:0], fwd_rk[1:0]}
    wire [10:0] oa = {ifa.stall_if_o, ifa.stall_id_o, ifa.stall_ex_o, ifa.stall_mem_o,
                      ifa.flush_id_o, ifa.flush_ex_o, ifa.flush_wb_o, ifa.fwd_rj_sel_o, ifa.fwd_rk_sel_o};
    wire [10:0] ob = {ifb.stall_if_o, ifb.stall_id_o, ifb.stall_ex_o, ifb.stall_mem_o,
                      ifb.flush_id_o, ifb.flush_ex_o, ifb.flush_wb_o, ifb.fwd_rj_sel_o, ifb.fwd_rk_sel_o};

    localparam logic [10:0] O_RST  = 11'b0000_111_00_00;
    localparam logic [10:0] O_IDLE = 11'b0000_000_00_00;
    localparam logic [10:0] O_MEM  = 11'b1111_001_00_00;
    localparam logic [10:0] O_RAW  = 11'b1100_010_00_00;
    localparam logic [10:0] O_BR   = 11'b0000_110_00_00;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [4:0]  rj, rk;
        logic        urj, urk;
        logic [4:0]  exrd;
        logic        exrw, exld;
        logic [4:0]  memrd;
        logic        memrw, br, req, ack;
        logic [10:0] exp_nf, exp_f;
        string       nm;
    } vec_t;

    vec_t vt[13];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic setv(input int i, input logic [4:0] rj, input logic [4:0] rk,
                        input logic urj, input logic urk, input logic [4:0] exrd,
                        input logic exrw, input logic exld, input logic [4:0] memrd,
                        input logic memrw, input logic br, input logic req, input logic ack,
                        input logic [10:0] exp_nf, input logic [10:0] exp_f, input string nm);
        vt[i].rj = rj;       vt[i].rk = rk;     vt[i].urj = urj;   vt[i].urk = urk;
        vt[i].exrd = exrd;   vt[i].exrw = exrw; vt[i].exld = exld;
        vt[i].memrd = memrd; vt[i].memrw = memrw;
        vt[i].br = br;       vt[i].req = req;   vt[i].ack = ack;
        vt[i].exp_nf = exp_nf; vt[i].exp_f = exp_f; vt[i].nm = nm;
    endtask

    task automatic drive_idle();
        ifa.id_rj_i = '0;  ifa.id_rk_i = '0;  ifa.id_use_rj_i = 1'b0; ifa.id_use_rk_i = 1'b0;
        ifa.ex_rd_i = '0;  ifa.ex_regwrite_i = 1'b0; ifa.ex_is_load_i = 1'b0;
        ifa.mem_rd_i = '0; ifa.mem_regwrite_i = 1'b0;
        ifa.br_taken_i = 1'b0; ifa.dm_req_i = 1'b0; ifa.dm_ack_i = 1'b0;
    endtask

    task automatic drive_load_use();
        ifa.id_rj_i = 5'd5; ifa.id_use_rj_i = 1'b1;
        ifa.ex_rd_i = 5'd5; ifa.ex_regwrite_i = 1'b1; ifa.ex_is_load_i = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive_idle();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_outs", 32'(oa), 32'(O_RST));
            chk("rst_cnt", 32'(ifa.stall_cnt_o), 32'd0);
            chk("rst_err", 32'(ifa.mem_err_o), 32'd0);
            next_cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", 32'(oa), 32'(O_IDLE));
        next_cycle();
    endtask

    initial begin
        int exp_cnt;
        logic [10:0] e;

        setv(0,  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE, O_IDLE, "idle");
        setv(1,  5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0, O_RAW, O_RAW, "load_use_rj");
        setv(2,  5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 5'd5, 1, 0, 0, 0, O_RAW, 11'b0000_000_00_01, "alu_rk_ex");
        setv(3,  5'd7, 5'd0, 1, 0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, O_RAW, 11'b0000_000_10_00, "mem_rj");
        setv(4,  5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, O_IDLE, O_IDLE, "r0_never");
        setv(5,  5'd5, 5'd5, 0, 0, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, O_IDLE, O_IDLE, "src_unused");
        setv(6,  5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 5'd5, 0, 0, 0, 0, O_IDLE, O_IDLE, "no_regwrite");
        setv(7,  5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 1, 0, 0, O_BR, O_BR, "br_over_raw");
        setv(8,  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, O_IDLE, O_IDLE, "zero_wait");
        setv(9,  5'd9, 5'd9, 1, 1, 5'd9, 1, 0, 5'd0, 0, 0, 0, 0, O_RAW, 11'b0000_000_01_01, "both_ex");
        setv(10, 5'd3, 5'd4, 1, 1, 5'd3, 1, 0, 5'd4, 1, 0, 0, 0, O_RAW, 11'b0000_000_01_10, "rj_ex_rk_mem");
        setv(11, 5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 5'd6, 1, 0, 0, 0, O_RAW, 11'b0000_000_01_00, "ex_over_mem");
        setv(12, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 0, 1, 1, O_RAW, O_RAW, "zero_wait_raw");

        // Reset held for 3 cycles, then released
        drive_idle();
        #1;
        do_reset(3);

        // RUN-state decode table
        exp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            ifa.id_rj_i = vt[i].rj;   ifa.id_rk_i = vt[i].rk;
            ifa.id_use_rj_i = vt[i].urj; ifa.id_use_rk_i = vt[i].urk;
            ifa.ex_rd_i = vt[i].exrd; ifa.ex_regwrite_i = vt[i].exrw; ifa.ex_is_load_i = vt[i].exld;
            ifa.mem_rd_i = vt[i].memrd; ifa.mem_regwrite_i = vt[i].memrw;
            ifa.br_taken_i = vt[i].br; ifa.dm_req_i = vt[i].req; ifa.dm_ack_i = vt[i].ack;
            e = FWD ? vt[i].exp_f : vt[i].exp_nf;
            if (e[10]) exp_cnt++;
            @(negedge clk);
            chk(vt[i].nm, 32'(oa), 32'(e));
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        chk("table_stall_cnt", 32'(ifa.stall_cnt_o), 32'(exp_cnt));
        next_cycle();

        // Memory wait with ack 4 cycles later; branch and RAW during the wait are ignored
        do_reset(1);
        ifa.dm_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ifa.br_taken_i = (k == 1 || k == 2);
            if (k == 2) drive_load_use();
            @(negedge clk);
            chk($sformatf("mem_wait_%0d", k), 32'(oa), 32'(O_MEM));
            next_cycle();
        end
        drive_idle();
        ifa.dm_req_i = 1'b1;
        ifa.dm_ack_i = 1'b1;
        @(negedge clk);
        chk("mem_ack_release", 32'(oa), 32'(O_IDLE));
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("mem_wait_cnt", 32'(ifa.stall_cnt_o), 32'd4);
        chk("mem_wait_cnt_c", 32'(ifc.stall_cnt_o), 32'd4);
        chk("mem_back_run", 32'(oa), 32'(O_IDLE));
        next_cycle();

        // Timeout on the TIMEOUT=3 instance; ERR is sticky and ignores ack
        do_reset(1);
        ifa.dm_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait_%0d", k), 32'(ob), 32'(O_MEM));
            chk($sformatf("to_noerr_%0d", k), 32'(ifb.mem_err_o), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("to_err_set", 32'(ifb.mem_err_o), 32'd1);
        chk("to_err_outs", 32'(ob), 32'(O_MEM));
        next_cycle();
        ifa.dm_ack_i = 1'b1;
        @(negedge clk);
        chk("to_ack_ignored", 32'(ob), 32'(O_MEM));
        chk("to_ack_err", 32'(ifb.mem_err_o), 32'd1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("to_err_held", 32'(ifb.mem_err_o), 32'd1);
        chk("to_err_stall", 32'(ob), 32'(O_MEM));
        next_cycle();

        // Long wait: counter saturation on the 3-bit instance, then reset mid-wait
        do_reset(1);
        ifa.dm_req_i = 1'b1;
        repeat (10) next_cycle();
        @(negedge clk);
        chk("long_cnt_a", 32'(ifa.stall_cnt_o), 32'd10);
        chk("sat_cnt_c", 32'(ifc.stall_cnt_o), 32'd7);
        rst = 1'b1;
        #1;
        chk("midwait_rst_outs", 32'(oa), 32'(O_RST));
        chk("midwait_rst_cnt", 32'(ifa.stall_cnt_o), 32'd0);
        chk("midwait_rst_err_b", 32'(ifb.mem_err_o), 32'd0);
        next_cycle();
        rst = 1'b0;
        ifa.dm_req_i = 1'b0;
        @(negedge clk);
        chk("midwait_run", 32'(oa), 32'(O_IDLE));
        next_cycle();
        drive_load_use();
        @(negedge clk);
        chk("midwait_raw_live", 32'(oa), 32'(O_RAW));
        next_cycle();
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
